// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring unsigned divider, one quotient bit per clock
// DW-bit dividend / VW-bit divisor with a start/done handshake and divide-by-zero flag.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dsr_q, dsr_d;
  logic [VW-1:0] part_q, part_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   shifted;
  logic          fits;
  logic [VW-1:0] diff;
  logic [VW-1:0] next_part;
  logic [DW-1:0] next_dvd;

  // The partial remainder stays below the divisor, so VW bits hold it; only the
  // shifted value needs the extra bit for the compare.
  always_comb begin
    shifted   = {part_q, dvd_q[DW-1]};
    fits      = (shifted >= {1'b0, dsr_q});
    diff      = shifted[VW-1:0] - dsr_q;
    next_part = fits ? diff : shifted[VW-1:0];
    next_dvd  = {dvd_q[DW-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      CALC: begin
        part_d = next_part;
        dvd_d  = next_dvd;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = next_dvd;
          rem_d   = next_part;
          dbz_d   = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            state_d = CALC;
            dvd_d   = dividend;
            dsr_d   = divisor;
            part_d  = '0;
            cnt_d   = CNT_LAST;
          end else begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
